// File: rtl/temporizador_quantum.sv
// Quantum preemption timer.
// Counts retired instructions (avanca_pc_i pulses) down from a programmable
// quantum. On expiry it saves the current PC and presents a jump word to the
// fetch stage, holding it until the fetch stage acknowledges. It then waits
// in the handler state until the handler reports completion.
//
// Ports:
//   clock_i               clock, rising edge
//   reset_ni              asynchronous active-low reset
//   habilita_i            preemption enable (level)
//   carrega_quantum_i     pulse: load valor_quantum_i into the quantum register
//   valor_quantum_i       new quantum, in retired instructions
//   endereco_tratador_i   jump target field of the injected word
//   avanca_pc_i           one-cycle pulse per instruction advanced
//   pc_atual_i            current PC
//   reconhece_i           fetch stage consumed the injected word
//   fim_tratador_i        pulse: handler finished
//   flag_temporizador_o   selects dado_temporizador_o in the instruction mux
//   dado_temporizador_o   injected jump word (zero while the flag is low)
//   pc_salvo_o            PC captured at expiry
//   contador_o            current down-counter value
//   num_preempcoes_o      expiries since reset, wraps at 256
module temporizador_quantum #(
  parameter int unsigned LARGURA_QUANTUM = 16,
  parameter logic [5:0]  OPCODE_DESVIO   = 6'b000010
) (
  input  logic                       clock_i,
  input  logic                       reset_ni,
  input  logic                       habilita_i,
  input  logic                       carrega_quantum_i,
  input  logic [LARGURA_QUANTUM-1:0] valor_quantum_i,
  input  logic [25:0]                endereco_tratador_i,
  input  logic                       avanca_pc_i,
  input  logic [31:0]                pc_atual_i,
  input  logic                       reconhece_i,
  input  logic                       fim_tratador_i,
  output logic                       flag_temporizador_o,
  output logic [31:0]                dado_temporizador_o,
  output logic [31:0]                pc_salvo_o,
  output logic [LARGURA_QUANTUM-1:0] contador_o,
  output logic [7:0]                 num_preempcoes_o
);

  localparam logic [LARGURA_QUANTUM-1:0] ContUm = LARGURA_QUANTUM'(1);

  typedef enum logic [1:0] {
    StOcioso,
    StContando,
    StDisparo,
    StTratando
  } estado_e;

  estado_e                    state_q, state_d;
  logic [LARGURA_QUANTUM-1:0] quantum_q, quantum_d;
  logic [LARGURA_QUANTUM-1:0] contador_q, contador_d;
  logic                       flag_q, flag_d;
  logic [31:0]                dado_q, dado_d;
  logic [31:0]                pc_salvo_q, pc_salvo_d;
  logic [7:0]                 num_q, num_d;

  always_comb begin
    state_d    = state_q;
    contador_d = contador_q;
    flag_d     = flag_q;
    dado_d     = dado_q;
    pc_salvo_d = pc_salvo_q;
    num_d      = num_q;
    // Reloads below read quantum_q, so a load on the same edge only takes
    // effect at the following reload.
    quantum_d  = carrega_quantum_i ? valor_quantum_i : quantum_q;

    unique case (state_q)
      StOcioso: begin
        if (habilita_i && (quantum_q != '0)) begin
          state_d    = StContando;
          contador_d = quantum_q;
        end
      end
      StContando: begin
        // Disable takes priority over a simultaneous expiry.
        if (!habilita_i) begin
          state_d = StOcioso;
        end else if (avanca_pc_i && (contador_q != '0)) begin
          contador_d = contador_q - ContUm;
          if (contador_q == ContUm) begin
            state_d    = StDisparo;
            flag_d     = 1'b1;
            dado_d     = {OPCODE_DESVIO, endereco_tratador_i};
            pc_salvo_d = pc_atual_i;
            num_d      = num_q + 8'd1;
          end
        end
      end
      StDisparo: begin
        // Enable is ignored here: the injected word must be consumed first.
        if (reconhece_i) begin
          state_d = StTratando;
          flag_d  = 1'b0;
          dado_d  = '0;
        end
      end
      StTratando: begin
        if (!habilita_i) begin
          state_d = StOcioso;
        end else if (fim_tratador_i) begin
          state_d    = StContando;
          contador_d = quantum_q;
        end
      end
      default: begin
        state_d = StOcioso;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= StOcioso;
      quantum_q  <= '0;
      contador_q <= '0;
      flag_q     <= 1'b0;
      dado_q     <= '0;
      pc_salvo_q <= '0;
      num_q      <= '0;
    end else begin
      state_q    <= state_d;
      quantum_q  <= quantum_d;
      contador_q <= contador_d;
      flag_q     <= flag_d;
      dado_q     <= dado_d;
      pc_salvo_q <= pc_salvo_d;
      num_q      <= num_d;
    end
  end

  assign flag_temporizador_o = flag_q;
  assign dado_temporizador_o = dado_q;
  assign pc_salvo_o          = pc_salvo_q;
  assign contador_o          = contador_q;
  assign num_preempcoes_o    = num_q;

endmodule

// File: tb/tb_temporizador_quantum.sv
// Scoreboard bench for temporizador_quantum: stimulus pushes hand-computed
// expected outputs, a monitor pops one entry per falling edge and compares.
module tb_temporizador_quantum;

  localparam logic [25:0] Addr = 26'h1234567;
  localparam logic [31:0] Word = {6'b000010, Addr};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        habilita, carrega, avanca, reconhece, fim;
  logic [15:0] valor;
  logic [25:0] endereco;
  logic [31:0] pc;
  logic        flag;
  logic [31:0] dado, pc_salvo;
  logic [15:0] contador;
  logic [7:0]  num;

  typedef struct packed {
    logic        flag;
    logic [31:0] dado;
    logic [31:0] pc;
    logic [15:0] cnt;
    logic [7:0]  num;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  exp_num = 8'd0;

  always #5 clk = ~clk;

  temporizador_quantum dut (
    .clock_i             (clk),
    .reset_ni            (rst_n),
    .habilita_i          (habilita),
    .carrega_quantum_i   (carrega),
    .valor_quantum_i     (valor),
    .endereco_tratador_i (endereco),
    .avanca_pc_i         (avanca),
    .pc_atual_i          (pc),
    .reconhece_i         (reconhece),
    .fim_tratador_i      (fim),
    .flag_temporizador_o (flag),
    .dado_temporizador_o (dado),
    .pc_salvo_o          (pc_salvo),
    .contador_o          (contador),
    .num_preempcoes_o    (num)
  );

  // Monitor: one expected entry checked per falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (flag !== e.flag || dado !== e.dado || pc_salvo !== e.pc ||
          contador !== e.cnt || num !== e.num) begin
        miscompares++;
        $display("FAIL vec%0d: got flag=%b dado=%h pc=%h cnt=%0d num=%0d, want flag=%b dado=%h pc=%h cnt=%0d num=%0d",
                 vectors, flag, dado, pc_salvo, contador, num,
                 e.flag, e.dado, e.pc, e.cnt, e.num);
      end
    end
  end

  task automatic chk(input logic f, input logic [31:0] d, input logic [31:0] p,
                     input logic [15:0] c, input logic [7:0] n);
    exp_t e;
    e.flag = f; e.dado = d; e.pc = p; e.cnt = c; e.num = n;
    sb.push_back(e);
  endtask

  // Advance one rising edge; inputs set before this are sampled on it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; habilita = 0; carrega = 0; avanca = 0; reconhece = 0; fim = 0;
    valor = '0; endereco = Addr; pc = '0;
    #1 chk(0, 0, 0, 0, 0);                      // reset state
    cyc();
    rst_n = 1'b1;

    // Enabled with quantum 0: stays idle, avanca has no effect.
    habilita = 1; avanca = 1;
    cyc(); chk(0, 0, 0, 0, 0);
    cyc(); chk(0, 0, 0, 0, 0);
    avanca = 0;

    // Load quantum 3; counting starts on the next edge.
    carrega = 1; valor = 16'd3;
    cyc(); chk(0, 0, 0, 0, 0);
    carrega = 0;
    cyc(); chk(0, 0, 0, 3, 0);
    cyc(); chk(0, 0, 0, 3, 0);                  // holds without avanca
    avanca = 1; reconhece = 1;                  // reconhece ignored here
    cyc(); chk(0, 0, 0, 2, 0);
    reconhece = 0;
    cyc(); chk(0, 0, 0, 1, 0);
    pc = 32'h40;
    cyc(); chk(1, Word, 32'h40, 0, 1);          // first expiry
    avanca = 0;

    // DISPARO: word held with habilita=0 and a stray fim_tratador.
    habilita = 0; fim = 1;
    for (int i = 0; i < 5; i++) begin
      cyc(); chk(1, Word, 32'h40, 0, 1);
    end
    fim = 0; habilita = 1; reconhece = 1;
    cyc(); chk(0, 0, 32'h40, 0, 1);             // -> TRATANDO
    reconhece = 0;

    // Load 5 while handling; then fim with a same-edge load of 7.
    carrega = 1; valor = 16'd5;
    cyc(); chk(0, 0, 32'h40, 0, 1);
    valor = 16'd7; fim = 1;
    cyc(); chk(0, 0, 32'h40, 5, 1);             // old quantum used
    carrega = 0; fim = 0;
    avanca = 1; pc = 32'h80;
    for (int i = 4; i >= 1; i--) begin
      cyc(); chk(0, 0, 32'h40, 16'(i), 1);
    end
    cyc(); chk(1, Word, 32'h80, 0, 2);          // second expiry
    avanca = 0; reconhece = 1;
    cyc(); chk(0, 0, 32'h80, 0, 2);
    reconhece = 0; fim = 1;
    cyc(); chk(0, 0, 32'h80, 7, 2);             // reload with 7
    fim = 0; avanca = 1;
    for (int i = 6; i >= 1; i--) begin
      cyc(); chk(0, 0, 32'h80, 16'(i), 2);
    end

    // Disable on the expiry edge: disable wins, counter held.
    habilita = 0;
    cyc(); chk(0, 0, 32'h80, 1, 2);
    cyc(); chk(0, 0, 32'h80, 1, 2);
    avanca = 0;

    // Quantum 1, expire, then disable with fim in TRATANDO -> OCIOSO.
    carrega = 1; valor = 16'd1;
    cyc(); chk(0, 0, 32'h80, 1, 2);
    carrega = 0; habilita = 1;
    cyc(); chk(0, 0, 32'h80, 1, 2);             // OCIOSO -> CONTANDO, cnt=1
    avanca = 1; pc = 32'hC0;
    cyc(); chk(1, Word, 32'hC0, 0, 3);
    avanca = 0; reconhece = 1;
    cyc(); chk(0, 0, 32'hC0, 0, 3);
    reconhece = 0; habilita = 0; fim = 1;
    cyc(); chk(0, 0, 32'hC0, 0, 3);             // disable beats fim
    fim = 0; habilita = 1;
    cyc(); chk(0, 0, 32'hC0, 1, 3);             // from OCIOSO, reload 1

    // Expire until the counter reaches 256 total and wraps to 0.
    exp_num = 8'd3;
    for (int k = 0; k < 253; k++) begin
      avanca = 1;
      exp_num = exp_num + 8'd1;
      cyc(); chk(1, Word, 32'hC0, 0, exp_num);
      avanca = 0;
      if (k != 252) begin
        reconhece = 1;
        cyc(); chk(0, 0, 32'hC0, 0, exp_num);
        reconhece = 0; fim = 1;
        cyc(); chk(0, 0, 32'hC0, 1, exp_num);
        fim = 0;
      end
    end
    chk(1, Word, 32'hC0, 0, 8'd0);              // wrapped, still DISPARO
    cyc();

    // Asynchronous reset between edges while in DISPARO.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk(0, 0, 0, 0, 0);
    cyc(); chk(0, 0, 0, 0, 0);
    rst_n = 1'b1; habilita = 1; avanca = 1;
    cyc(); chk(0, 0, 0, 0, 0);                  // quantum cleared: stays idle
    cyc(); chk(0, 0, 0, 0, 0);
    avanca = 0;

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/temporizador_quantum.md
TEMPORIZADOR_QUANTUM -- requirements
Module: temporizador_quantum

Interface
REQ-001 Parameter LARGURA_QUANTUM, default 16, width of quantum register and down-counter.
REQ-002 Parameter OPCODE_DESVIO, default 6'b000010, opcode placed in bits [31:26] of the injected jump word.
REQ-003 clock  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; one clock, reset is asynchronous and active-low.
REQ-005 habilita  input  1  preemption enable, level.
REQ-006 carrega_quantum  input  1  pulse; load valor_quantum into quantum register.
REQ-007 valor_quantum  input  LARGURA_QUANTUM  new quantum, in retired instructions.
REQ-008 endereco_tratador  input  26  handler jump target field.
REQ-009 avanca_pc  input  1  one-cycle pulse per instruction advanced.
REQ-010 pc_atual  input  32  current PC.
REQ-011 reconhece  input  1  fetch stage consumed the injected word.
REQ-012 fim_tratador  input  1  pulse; handler finished.
REQ-013 flag_temporizador  output  1  registered; selects dado_temporizador in the instruction mux.
REQ-014 dado_temporizador  output  32  registered injected jump word.
REQ-015 pc_salvo  output  32  PC captured at expiry.
REQ-016 contador  output  LARGURA_QUANTUM  current down-counter value.
REQ-017 num_preempcoes  output  8  expiries since reset, wraps 255->0.

Function
REQ-018 FSM states: OCIOSO, CONTANDO, DISPARO, TRATANDO; one state register.
REQ-019 OCIOSO -> CONTANDO when habilita=1 and quantum register nonzero; contador loads quantum register on that edge.
REQ-020 OCIOSO with habilita=1 and quantum register 0: stays OCIOSO.
REQ-021 CONTANDO: contador decrements by 1 on each edge with avanca_pc=1; holds otherwise.
REQ-022 CONTANDO with contador=1 and avanca_pc=1: contador->0, state->DISPARO, flag_temporizador->1, dado_temporizador->{OPCODE_DESVIO, endereco_tratador}, pc_salvo->pc_atual, num_preempcoes increments, all on the same edge.
REQ-023 CONTANDO with habilita=0: -> OCIOSO next edge, contador held, no flag; disable wins over simultaneous expiry.
REQ-024 DISPARO: flag_temporizador and dado_temporizador held stable until an edge with reconhece=1; habilita=0 ignored in this state.
REQ-025 DISPARO with reconhece=1: -> TRATANDO, flag_temporizador->0, dado_temporizador->0.
REQ-026 TRATANDO with fim_tratador=1 and habilita=1: -> CONTANDO, contador reloads quantum register.
REQ-027 TRATANDO with habilita=0: -> OCIOSO (priority over fim_tratador).
REQ-028 carrega_quantum=1 updates quantum register in any state; never alters contador directly; new value takes effect at next load (REQ-019/026).
REQ-029 carrega_quantum on the same edge as a reload: reload uses the old quantum value.
REQ-030 dado_temporizador=0 whenever flag_temporizador=0.
REQ-031 reconhece or fim_tratador outside the state that consumes them: ignored.

Reset
REQ-032 reset=0 asynchronously forces OCIOSO, quantum register 0, contador 0, flag_temporizador 0, dado_temporizador 0, pc_salvo 0, num_preempcoes 0.
REQ-033 Reset asserted in DISPARO drops flag_temporizador immediately, without a clock edge.
REQ-034 After reset release, habilita=1 with quantum 0 stays OCIOSO until carrega_quantum.

Verification
REQ-035 load quantum 3, habilita=1, 3 avanca_pc pulses with pc_atual=0x40 on the third -> flag=1 after third edge, dado_temporizador={6'b000010, endereco_tratador}, pc_salvo=0x40, num_preempcoes=1.
REQ-036 in DISPARO hold reconhece=0 for 5 cycles with habilita=0 -> flag and word stay stable; reconhece=1 -> flag=0, dado=0, state TRATANDO.
REQ-037 TRATANDO, carrega_quantum with 5, fim_tratador pulse -> contador=5, CONTANDO; 5 pulses -> second expiry.
REQ-038 CONTANDO with contador=1, habilita=0 and avanca_pc=1 same edge -> OCIOSO, flag stays 0, num_preempcoes unchanged.
REQ-039 drive reset low mid-DISPARO between edges -> all outputs 0 immediately; 256 expiries -> num_preempcoes wraps to 0.
